// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types for the video blocks.
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
    localparam vga_timing_t Vga640H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_timing_t Vga480V = '{active: 480, fp: 10, sync: 2, bp: 33};
    localparam bit Vga640HPol = 1'b0;
    localparam bit Vga480VPol = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
    localparam vga_timing_t Vga800H = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam vga_timing_t Vga600V = '{active: 600, fp: 1, sync: 4, bp: 23};
    localparam bit Vga800HPol = 1'b1;
    localparam bit Vga600VPol = 1'b1;

    function automatic int axisTotal(vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync region decode.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : gParamCheck
        $fatal(1, "vga_axis_counter: ACTIVE, FP, SYNC and BP must all be >= 1");
    end

    localparam logic [W-1:0] Last      = W'(TOTAL - 1);
    localparam logic [W-1:0] ActiveEnd = W'(ACTIVE);
    localparam logic [W-1:0] SyncStart = W'(ACTIVE + FP);
    localparam logic [W-1:0] SyncEnd   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] countQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            countQ <= '0;
        end else if (en) begin
            countQ <= wrap ? '0 : countQ + 1'b1;
        end
    end

    assign count  = countQ;
    assign wrap   = en && (countQ == Last);
    assign active = countQ < ActiveEnd;
    assign sync   = (countQ >= SyncStart && countQ < SyncEnd) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Configurable VGA raster timing generator with registered, mutually aligned outputs.
// Define VGA_PIXEL_TICK_EN to add a pix_tick advance enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = Vga640H.active,
    parameter int H_FP       = Vga640H.fp,
    parameter int H_SYNC     = Vga640H.sync,
    parameter int H_BP       = Vga640H.bp,
    parameter int V_ACTIVE   = Vga480V.active,
    parameter int V_FP       = Vga480V.fp,
    parameter int V_SYNC     = Vga480V.sync,
    parameter int V_BP       = Vga480V.bp,
    parameter bit H_SYNC_POL = Vga640HPol,
    parameter bit V_SYNC_POL = Vga480VPol,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W       = $clog2(H_TOTAL),
    localparam int Y_W       = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset,
`ifdef VGA_PIXEL_TICK_EN
    input  logic           pix_tick,
`endif
    output logic           vga_h_sync,
    output logic           vga_v_sync,
    output logic           display_en,
    output logic [X_W-1:0] CounterX,
    output logic [Y_W-1:0] CounterY,
    output logic           line_start,
    output logic           frame_start
);

    logic advance;
`ifdef VGA_PIXEL_TICK_EN
    assign advance = pix_tick;
`else
    assign advance = 1'b1;
`endif

    logic [X_W-1:0] hcnt;
    logic [Y_W-1:0] vcnt;
    logic           hWrap, hActive, hSync;
    logic           unusedVWrap, vActive, vSync;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL)
    ) uHAxis (
        .clk    (clk),
        .reset  (reset),
        .en     (advance),
        .count  (hcnt),
        .wrap   (hWrap),
        .active (hActive),
        .sync   (hSync)
    );

    // hWrap already includes advance, so lines only step on a real advance.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL)
    ) uVAxis (
        .clk    (clk),
        .reset  (reset),
        .en     (hWrap),
        .count  (vcnt),
        .wrap   (unusedVWrap),
        .active (vActive),
        .sync   (vSync)
    );

    logic lineDecode, frameDecode;
    assign lineDecode  = advance && (hcnt == '0);
    assign frameDecode = lineDecode && (vcnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            CounterX    <= '0;
            CounterY    <= '0;
            display_en  <= 1'b0;
            vga_h_sync  <= ~H_SYNC_POL;
            vga_v_sync  <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes reload every clk so they drop on hold cycles.
            line_start  <= lineDecode;
            frame_start <= frameDecode;
            if (advance) begin
                CounterX   <= hcnt;
                CounterY   <= vcnt;
                display_en <= hActive && vActive;
                vga_h_sync <= hSync;
                vga_v_sync <= vSync;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench: default 640x480 instance plus a tiny 8x6 raster instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pixTick = 1'b1;
    always #5 clk = ~clk;

    logic       hs, vs, de, ls, fs;
    logic [9:0] cx, cy;
    logic       hsS, vsS, deS, lsS, fsS;
    logic [2:0] cxS, cyS;

    int tests = 0;
    int failures = 0;

    vga_timing_gen dut (
        .clk         (clk),
        .reset       (reset),
`ifdef VGA_PIXEL_TICK_EN
        .pix_tick    (pixTick),
`endif
        .vga_h_sync  (hs),
        .vga_v_sync  (vs),
        .display_en  (de),
        .CounterX    (cx),
        .CounterY    (cy),
        .line_start  (ls),
        .frame_start (fs)
    );

    vga_timing_gen #(
        .H_ACTIVE   (4),
        .H_FP       (1),
        .H_SYNC     (2),
        .H_BP       (1),
        .V_ACTIVE   (3),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b0)
    ) dutS (
        .clk         (clk),
        .reset       (reset),
`ifdef VGA_PIXEL_TICK_EN
        .pix_tick    (pixTick),
`endif
        .vga_h_sync  (hsS),
        .vga_v_sync  (vsS),
        .display_en  (deS),
        .CounterX    (cxS),
        .CounterY    (cyS),
        .line_start  (lsS),
        .frame_start (fsS)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int ex, ey, exS, eyS;
    int seqErr, hErr, deErr, lsErr, fsErr, vErr;
    int hLow, hMin, hMax, deCnt, deMax;
    int seqErrS, hsErrS, deErrS, lsErrS, vsErrS, fsErrS, hsHighS, vsLowS, vsTransBadS, fsCntS;
    logic prevVsS;
`ifdef VGA_PIXEL_TICK_EN
    int lsCnt, lsFirstK;
`endif

    initial begin
        seqErr = 0; hErr = 0; deErr = 0; lsErr = 0; fsErr = 0; vErr = 0;
        hLow = 0; hMin = 9999; hMax = -1; deCnt = 0; deMax = -1;
        seqErrS = 0; hsErrS = 0; deErrS = 0; lsErrS = 0; vsErrS = 0; fsErrS = 0;
        hsHighS = 0; vsLowS = 0; vsTransBadS = 0; fsCntS = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cx", 32'(cx), 0);
        check("rst_cy", 32'(cy), 0);
        check("rst_de", 32'(de), 0);
        check("rst_ls", 32'(ls), 0);
        check("rst_fs", 32'(fs), 0);
        check("rst_hs", 32'(hs), 1);
        check("rst_vs", 32'(vs), 1);
        check("rst_hs_small", 32'(hsS), 0);
        check("rst_vs_small", 32'(vsS), 1);

        reset = 1'b0;
        @(negedge clk);
        check("first_cx", 32'(cx), 0);
        check("first_cy", 32'(cy), 0);
        check("first_de", 32'(de), 1);
        check("first_ls", 32'(ls), 1);
        check("first_fs", 32'(fs), 1);
        check("first_fs_small", 32'(fsS), 1);
        prevVsS = vsS;

        // Sample c is the output after the (c+1)-th advance since release.
        for (int c = 0; c <= 16300; c++) begin
            if (c > 0) @(negedge clk);
            ex = c % 800;
            ey = c / 800;
            if (int'(cx) != ex || int'(cy) != ey) seqErr++;
            if (hs !== ((ex >= 656 && ex <= 751) ? 1'b0 : 1'b1)) hErr++;
            if (de !== ((ex < 640 && ey < 480) ? 1'b1 : 1'b0)) deErr++;
            if (ls !== ((ex == 0) ? 1'b1 : 1'b0)) lsErr++;
            if (fs !== ((c == 0) ? 1'b1 : 1'b0)) fsErr++;
            if (vs !== 1'b1) vErr++;
            if (c < 800) begin
                if (hs === 1'b0) begin
                    hLow++;
                    if (int'(cx) < hMin) hMin = int'(cx);
                    if (int'(cx) > hMax) hMax = int'(cx);
                end
                if (de === 1'b1) begin
                    deCnt++;
                    deMax = int'(cx);
                end
            end

            exS = c % 8;
            eyS = (c / 8) % 6;
            if (int'(cxS) != exS || int'(cyS) != eyS) seqErrS++;
            if (hsS !== ((exS == 5 || exS == 6) ? 1'b1 : 1'b0)) hsErrS++;
            if (deS !== ((exS < 4 && eyS < 3) ? 1'b1 : 1'b0)) deErrS++;
            if (lsS !== ((exS == 0) ? 1'b1 : 1'b0)) lsErrS++;
            if (vsS !== ((eyS == 4) ? 1'b0 : 1'b1)) vsErrS++;
            if (fsS !== ((c % 48 == 0) ? 1'b1 : 1'b0)) fsErrS++;
            if (c < 8 && hsS === 1'b1) hsHighS++;
            if (c < 48 && vsS === 1'b0) vsLowS++;
            if (c > 0 && vsS !== prevVsS && cxS !== 3'd0) vsTransBadS++;
            prevVsS = vsS;
            if (fsS === 1'b1) fsCntS++;
        end

        check("raster_sequence", 32'(seqErr), 0);
        check("hsync_region_errs", 32'(hErr), 0);
        check("hsync_low_cycles", 32'(hLow), 96);
        check("hsync_low_first_x", 32'(hMin), 656);
        check("hsync_low_last_x", 32'(hMax), 751);
        check("de_line_cycles", 32'(deCnt), 640);
        check("de_last_x", 32'(deMax), 639);
        check("de_errs", 32'(deErr), 0);
        check("line_start_errs", 32'(lsErr), 0);
        check("frame_start_errs", 32'(fsErr), 0);
        check("vsync_idle_errs", 32'(vErr), 0);
        check("small_sequence", 32'(seqErrS), 0);
        check("small_hsync_errs", 32'(hsErrS), 0);
        check("small_hsync_high_cycles", 32'(hsHighS), 2);
        check("small_de_errs", 32'(deErrS), 0);
        check("small_ls_errs", 32'(lsErrS), 0);
        check("small_vsync_errs", 32'(vsErrS), 0);
        check("small_vsync_low_cycles", 32'(vsLowS), 8);
        check("small_vsync_midline_edges", 32'(vsTransBadS), 0);
        check("small_fs_errs", 32'(fsErrS), 0);
        check("small_fs_count", 32'(fsCntS), 340);

        // Outputs currently show (300,20); reset lands on the next edge.
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cx", 32'(cx), 0);
        check("midrst_cy", 32'(cy), 0);
        check("midrst_de", 32'(de), 0);
        check("midrst_ls", 32'(ls), 0);
        check("midrst_hs", 32'(hs), 1);
        reset = 1'b0;
        @(negedge clk);
        check("restart_cx", 32'(cx), 0);
        check("restart_cy", 32'(cy), 0);
        check("restart_fs", 32'(fs), 1);
        check("restart_de", 32'(de), 1);

`ifdef VGA_PIXEL_TICK_EN
        lsCnt = 0;
        lsFirstK = -1;
        for (int k = 1; k <= 3203; k++) begin
            pixTick = (k % 4 == 0);
            @(negedge clk);
            if (k == 4) check("tick_step_x", 32'(cx), 1);
            if (k == 5) check("tick_hold_x", 32'(cx), 1);
            if (k == 5) check("tick_hold_ls", 32'(ls), 0);
            if (ls === 1'b1) begin
                lsCnt++;
                if (lsFirstK < 0) lsFirstK = k;
            end
            if (k == 3200) check("tick_line_y", 32'(cy), 1);
            if (k == 3201) check("tick_wrap_hold_x", 32'(cx), 0);
        end
        check("tick_line_clks", 32'(lsFirstK), 3200);
        check("tick_ls_width", 32'(lsCnt), 1);
`else
        @(negedge clk);
        check("restart_next_x", 32'(cx), 1);
        check("restart_next_fs", 32'(fs), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
